// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge slice.
package apb_pkg;

   localparam int APB_ADDR_WIDTH = 8;
   localparam int APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus signals; master = bridge side, slave = its environment.
interface apb_master_bridge_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH = APB_DATA_WIDTH
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_error;

   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait counter; expired flags the last permitted wait cycle.
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != LIMIT)) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   // High while a stalled ACCESS cycle would bring the count to TIMEOUT.
   assign expired = (count_reg >= LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: command handshake -> SETUP/ACCESS -> one-cycle response.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH = APB_DATA_WIDTH,
   parameter int TIMEOUT    = 16
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb_master_bridge_if.master bus
);

   apb_state_t            state_reg, state_next;
   logic                  alive_reg;
   logic                  cmd_ready, psel, penable;
   logic                  handshake, access_done, timed_out, expired;
   logic [ADDR_WIDTH-1:0] paddr_reg;
   logic [DATA_WIDTH-1:0] pwdata_reg;
   logic                  pwrite_reg;
   logic                  rsp_valid_reg, rsp_error_reg;
   logic [DATA_WIDTH-1:0] rsp_rdata_reg;

   assign handshake   = bus.cmd_valid && cmd_ready;
   assign access_done = (state_reg == ACCESS) && bus.PREADY;
   assign timed_out   = (state_reg == ACCESS) && !bus.PREADY && expired;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .clear   (handshake),
      .enable  ((state_reg == ACCESS) && !bus.PREADY),
      .expired (expired)
   );

   // alive_reg keeps cmd_ready low while reset is held.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_reg <= IDLE;
         alive_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         alive_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (handshake) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (bus.PREADY || expired) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      case (state_reg)
         IDLE:    cmd_ready = alive_reg;
         SETUP:   psel = 1'b1;
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         paddr_reg  <= '0;
         pwrite_reg <= 1'b0;
         pwdata_reg <= '0;
      end else if (handshake) begin
         paddr_reg  <= bus.cmd_addr;
         pwrite_reg <= bus.cmd_write;
         pwdata_reg <= bus.cmd_wdata;
      end
   end

   // PREADY has priority over an expiring wait counter.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         rsp_valid_reg <= 1'b0;
         rsp_error_reg <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         rsp_valid_reg <= access_done || timed_out;
         rsp_error_reg <= timed_out;
         rsp_rdata_reg <= (access_done && !pwrite_reg) ? bus.PRDATA : '0;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.PSEL      = psel;
   assign bus.PENABLE   = penable;
   assign bus.PADDR     = paddr_reg;
   assign bus.PWRITE    = pwrite_reg;
   assign bus.PWDATA    = pwdata_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_error = rsp_error_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with an APB slave model and a response scoreboard.
module tb_apb_master_bridge;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   logic PCLK;
   logic PRESET;

   apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   apb_master_bridge #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .TIMEOUT    (16)
   ) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb_q[$];

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave model: waits programmable wait states, or stalls forever.
   logic [31:0] mem [256];
   int          acc_cnt = 0;
   int          waits = 0;
   bit          stall = 1'b0;

   always @(posedge PCLK) begin
      if (bus.PSEL && bus.PENABLE) acc_cnt <= acc_cnt + 1;
      else                         acc_cnt <= 0;
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
   end

   always_comb begin
      bus.PREADY = bus.PSEL && bus.PENABLE && !stall && (acc_cnt >= waits);
      bus.PRDATA = bus.PREADY ? mem[bus.PADDR] : 32'hBAD0_BAD0;
   end

   // Monitor: phase/stability checks and scoreboard comparison on each response.
   int          hs_cyc = 0;
   int          hs_count = 0;
   int          age = 0;
   int          acc_len = 0;
   bit          in_xfer = 1'b0;
   logic [7:0]  cap_addr = '0;
   logic        cap_write = 1'b0;
   logic [31:0] cap_wdata = '0;
   exp_t        got;

   always @(negedge PCLK) begin
      if (!PRESET) begin
         in_xfer = 1'b0;
      end else begin
         if (in_xfer) begin
            age++;
            if (age == 1) begin
               chk("setup_psel", bus.PSEL, 1);
               chk("setup_penable", bus.PENABLE, 0);
            end
            if (age == 2) begin
               chk("access_psel", bus.PSEL, 1);
               chk("access_penable", bus.PENABLE, 1);
            end
            if (bus.PSEL) begin
               chk("paddr_stable", bus.PADDR, cap_addr);
               chk("pwrite_stable", bus.PWRITE, cap_write);
               if (cap_write) chk("pwdata_stable", bus.PWDATA, cap_wdata);
            end
            if (bus.PSEL && bus.PENABLE) acc_len++;
         end else begin
            chk("idle_psel", bus.PSEL, 0);
         end
         if (bus.rsp_valid) begin
            chk("rsp_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               got = sb_q.pop_front();
               $display("RSP addr=%0h write=%0b rdata=%0h error=%0b latency=%0d access=%0d",
                        cap_addr, cap_write, bus.rsp_rdata, bus.rsp_error, cyc - hs_cyc, acc_len);
               chk("rsp_rdata", bus.rsp_rdata, got.rdata);
               chk("rsp_error", bus.rsp_error, got.err);
               chk("rsp_latency", cyc - hs_cyc, got.lat);
               chk("access_len", acc_len, got.acc);
            end
            in_xfer = 1'b0;
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            hs_cyc    = cyc;
            hs_count++;
            cap_addr  = bus.cmd_addr;
            cap_write = bus.cmd_write;
            cap_wdata = bus.cmd_wdata;
            in_xfer   = 1'b1;
            age       = 0;
            acc_len   = 0;
         end
      end
   end

   task automatic push_exp(input logic [31:0] er, input bit ee, input int el, input int ea);
      exp_t x;
      x.rdata = er;
      x.err   = ee;
      x.lat   = el;
      x.acc   = ea;
      sb_q.push_back(x);
   endtask

   task automatic send(input bit wr, input logic [7:0] a, input logic [31:0] d);
      bit ok;
      ok            = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK);
         if (bus.cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge PCLK);
      #1;
      bus.cmd_valid = 1'b0;
      chk("handshake_wait", ok, 1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (sb_q.size() == 0) break;
         @(posedge PCLK);
         #1;
      end
      chk("rsp_wait", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] er, input bit ee, input int el, input int ea);
      push_exp(er, ee, el, ea);
      send(wr, a, d);
      wait_drain();
   endtask

   int prev;
   int hs_base;
   bit ok;

   initial begin
      PRESET        = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;

      // Reset values while PRESET is low
      repeat (3) @(negedge PCLK);
      chk("rst_psel", bus.PSEL, 0);
      chk("rst_penable", bus.PENABLE, 0);
      chk("rst_pwrite", bus.PWRITE, 0);
      chk("rst_paddr", bus.PADDR, 0);
      chk("rst_pwdata", bus.PWDATA, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_error", bus.rsp_error, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      @(posedge PCLK);
      #2 PRESET = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("release_cmd_ready", bus.cmd_ready, 1);
      @(posedge PCLK);
      #1;

      // Zero-wait write, then read back
      issue(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1);
      issue(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1);

      // Three wait states on a read of 0x20
      issue(1'b1, 8'h20, 32'h1234_5678, 32'h0, 1'b0, 3, 1);
      waits = 3;
      issue(1'b0, 8'h20, 32'h0, 32'h1234_5678, 1'b0, 6, 4);

      // PREADY arriving on the final permitted cycle still succeeds
      waits = 15;
      issue(1'b0, 8'h20, 32'h0, 32'h1234_5678, 1'b0, 18, 16);
      waits = 0;

      // Permanent stall: timeout, then a normal transfer
      stall = 1'b1;
      issue(1'b0, 8'h30, 32'h0, 32'h0, 1'b1, 18, 16);
      stall = 1'b0;
      issue(1'b1, 8'h30, 32'hA5A5_A5A5, 32'h0, 1'b0, 3, 1);
      issue(1'b0, 8'h30, 32'h0, 32'hA5A5_A5A5, 1'b0, 3, 1);

      // cmd_valid held high across four writes
      for (int i = 0; i < 4; i++) push_exp(32'h0, 1'b0, 3, 1);
      hs_base       = hs_count;
      prev          = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.cmd_addr  = 8'(8'h40 + i);
         bus.cmd_wdata = 32'(32'h1111_1111 * (i + 1));
         ok = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (bus.cmd_ready) begin
               ok = 1'b1;
               break;
            end
         end
         chk("b2b_handshake", ok, 1);
         if (i > 0) chk("b2b_gap", cyc - prev, 3);
         prev = cyc;
         @(posedge PCLK);
         #1;
      end
      bus.cmd_valid = 1'b0;
      wait_drain();
      chk("b2b_count", hs_count - hs_base, 4);
      for (int i = 0; i < 4; i++)
         issue(1'b0, 8'(8'h40 + i), 32'h0, 32'(32'h1111_1111 * (i + 1)), 1'b0, 3, 1);

      // Reset during ACCESS aborts silently
      stall = 1'b1;
      send(1'b1, 8'h50, 32'h0BAD_F00D);
      repeat (3) begin
         @(posedge PCLK);
         #1;
      end
      chk("pre_abort_penable", bus.PENABLE, 1);
      PRESET = 1'b0;
      #1;
      chk("abort_psel", bus.PSEL, 0);
      chk("abort_penable", bus.PENABLE, 0);
      chk("abort_rsp_valid", bus.rsp_valid, 0);
      chk("abort_cmd_ready", bus.cmd_ready, 0);
      stall = 1'b0;
      push_exp(32'hDEAD_BEEF, 1'b0, 3, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h10;
      @(posedge PCLK);
      #2 PRESET = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("post_abort_cmd_ready", bus.cmd_ready, 1);
      @(posedge PCLK);
      #1;
      bus.cmd_valid = 1'b0;
      wait_drain();
      issue(1'b0, 8'h50, 32'h0, 32'hX, 1'b0, 3, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers and returns a one-cycle response pulse. It sits directly upstream of the APB slave and drives its PSEL, PENABLE, PADDR, PWRITE and PWDATA inputs. It consumes PREADY and PRDATA from the slave and terminates stalled transfers with an error after a bounded wait.

## Interface
- ADDR_WIDTH, 8, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles without PREADY before error termination (≥1)

Reset PRESET, asynchronous, active-low; clock PCLK.
- PCLK  in  1  APB clock, all logic rising-edge
- PRESET  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_error  out  1  transfer timed out
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WIDTH  slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On handshake, latch cmd into PADDR/PWRITE/PWDATA, go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: go to IDLE, pulse rsp_valid next cycle. rsp_rdata = PRDATA if read, else 0. rsp_error=0.
  - PREADY=0: increment wait counter.
  - Counter reaches TIMEOUT: go to IDLE, pulse rsp_valid with rsp_error=1, rsp_rdata=0.
- Wait counter clears on entry to SETUP. Width is clog2(TIMEOUT+1); it never wraps.
- cmd_ready=0 in SETUP and ACCESS. cmd_valid there is ignored, not queued.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They hold their last values in IDLE.
- PREADY and PRDATA are ignored outside ACCESS.
- Reset mid-transfer: every output goes to its reset value immediately, FSM goes to IDLE, and no response is issued for the aborted command.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, cmd_ready=0 while PRESET low, cmd_ready=1 from the first cycle after release.

## Timing
- All outputs are registered; none are combinational from inputs. cmd_ready is decoded from the state register.
- Edge numbering, zero wait states:
  - Handshake at edge 0.
  - SETUP in cycle 0–1.
  - ACCESS in cycle 1–2, PREADY sampled at edge 2.
  - rsp_valid high in cycle 2–3; FSM is back in IDLE with cmd_ready=1 in that same cycle.
- Command-to-response latency is 3 cycles plus N wait cycles.
- Back-to-back throughput is one transfer per 3 cycles.
- Timeout: with PREADY held 0, ACCESS lasts TIMEOUT cycles, then the error rsp_valid follows.
- If PREADY=1 in the same cycle the counter reaches TIMEOUT, it is a success (PREADY wins).

## Structure
- Shared package apb_pkg:
  - 2-bit state typedef (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10)
  - default ADDR_WIDTH/DATA_WIDTH constants
- Sub-module apb_wait_timer: clear/enable counter with an expired flag, parameterised by TIMEOUT. It is instantiated once.
- Everything else (FSM, capture registers, response register) is in the top level.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, slave with zero waits: PSEL rises the cycle after the handshake, PENABLE rises one cycle later, rsp_valid pulses 3 cycles after the handshake with rsp_error=0.
- Read addr 0x10 after that write: rsp_rdata=0xDEADBEEF, rsp_error=0, PWRITE=0 throughout SETUP/ACCESS.
- Slave inserts 3 wait states on a read of 0x20 returning 0x12345678: ACCESS lasts 4 cycles, PADDR is stable the whole time, rsp_valid arrives at latency 6.
- PREADY tied 0, TIMEOUT=16: ACCESS lasts 16 cycles, then rsp_valid=1, rsp_error=1, rsp_rdata=0. The next command proceeds normally.
- cmd_valid held high continuously across 4 writes: exactly 4 handshakes, each 3 cycles apart, with no command dropped or duplicated.
- PRESET asserted during ACCESS: PSEL and PENABLE drop to 0 immediately, no rsp_valid pulse, and a handshake completes on the first cycle after release.
